// File: rtl/pipe_datapath.sv
// pipe_datapath: five-stage (IF/ID/EX/MEM/WB) RV32-style integer datapath.
// Owns the PC, pipeline registers, 32-entry register file, ALU, operand forwarding,
// load-use stall and EX-resolved branch/jump flush. Decoding is done by an external
// controller that looks at instrD and drives the *D control inputs.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   pcF / instrF        fetch address out, instruction at pcF in (combinational)
//   instrD              ID-stage instruction to the controller
//   *D control, simmD   ID-stage control and sign-extended immediate
//   aluoutM, writedataM data address and store data in MEM
//   memwriteM           store strobe in MEM
//   readdataM           load data in MEM (combinational)
//
// Optional: define PIPE_DATAPATH_PERF_EN to add cycle_cnt, retire_cnt and stall_cnt.
module pipe_datapath #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] pcF,
    input  logic [31:0]     instrF,
    output logic [31:0]     instrD,
    input  logic            regwriteD,
    input  logic            memtoregD,
    input  logic            memwriteD,
    input  logic            alusrcimmD,
    input  logic            jumpD,
    input  logic            branchD,
    input  logic            branchneD,
    input  logic [3:0]      alucontrolD,
    input  logic [XLEN-1:0] simmD,
    output logic [XLEN-1:0] aluoutM,
    output logic [XLEN-1:0] writedataM,
    output logic            memwriteM,
    input  logic [XLEN-1:0] readdataM
`ifdef PIPE_DATAPATH_PERF_EN
    ,
    output logic [31:0]     cycle_cnt,
    output logic [31:0]     retire_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int unsigned ShW = $clog2(XLEN);

    // An all-zero pipeline register is a bubble: instr 0 and every control bit 0.
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } if_id_t;

    typedef struct packed {
        logic            regwrite, memtoreg, memwrite, alusrcimm, jump, branch, branchne;
        logic [3:0]      alucontrol;
        logic [4:0]      rs1, rs2, rd;
        logic [XLEN-1:0] rd1, rd2, simm, pc;
    } id_ex_t;

    typedef struct packed {
        logic            regwrite, memtoreg, memwrite, jump;
        logic [4:0]      rd;
        logic [XLEN-1:0] aluout, writedata, pcplus4;
    } ex_mem_t;

    typedef struct packed {
        logic            regwrite, memtoreg, jump;
        logic [4:0]      rd;
        logic [XLEN-1:0] aluout, readdata, pcplus4;
    } mem_wb_t;

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    id_ex_t          id_ex_q, id_ex_d;
    ex_mem_t         ex_mem_q, ex_mem_d;
    mem_wb_t         mem_wb_q, mem_wb_d;
    logic [XLEN-1:0] rf_q [32];
    logic [XLEN-1:0] rf_d [32];

    logic [4:0]      rs1D, rs2D;
    logic [XLEN-1:0] rd1D, rd2D, resultW, fwd_m;
    logic [XLEN-1:0] srcaE, wdataE, srcbE, aluE, pcplus4E, targetE;
    logic [ShW-1:0]  shamt;
    logic            takenE, lwstall;

    assign rs1D = if_id_q.instr[19:15];
    assign rs2D = if_id_q.instr[24:20];

    assign resultW = mem_wb_q.memtoreg ? mem_wb_q.readdata :
                     (mem_wb_q.jump ? mem_wb_q.pcplus4 : mem_wb_q.aluout);

    // Register read with same-cycle WB bypass; x0 always reads 0.
    always_comb begin
        rd1D = '0;
        rd2D = '0;
        if (rs1D != 5'd0) begin
            rd1D = (mem_wb_q.regwrite && mem_wb_q.rd == rs1D) ? resultW : rf_q[rs1D];
        end
        if (rs2D != 5'd0) begin
            rd2D = (mem_wb_q.regwrite && mem_wb_q.rd == rs2D) ? resultW : rf_q[rs2D];
        end
    end

    // A jump in MEM forwards its link value rather than its ALU result.
    assign fwd_m = ex_mem_q.jump ? ex_mem_q.pcplus4 : ex_mem_q.aluout;

    always_comb begin
        srcaE  = id_ex_q.rd1;
        wdataE = id_ex_q.rd2;
        if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs1) begin
            srcaE = fwd_m;
        end else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs1) begin
            srcaE = resultW;
        end
        if (ex_mem_q.regwrite && ex_mem_q.rd != 5'd0 && ex_mem_q.rd == id_ex_q.rs2) begin
            wdataE = fwd_m;
        end else if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0 && mem_wb_q.rd == id_ex_q.rs2) begin
            wdataE = resultW;
        end
    end

    assign srcbE = id_ex_q.alusrcimm ? id_ex_q.simm : wdataE;
    assign shamt = srcbE[ShW-1:0];

    always_comb begin
        aluE = '0;
        case (id_ex_q.alucontrol)
            4'b0000: aluE = srcaE + srcbE;
            4'b0001: aluE = srcaE - srcbE;
            4'b0010: aluE = srcaE & srcbE;
            4'b0011: aluE = srcaE | srcbE;
            4'b0100: aluE = srcaE ^ srcbE;
            4'b0101: aluE = {{(XLEN-1){1'b0}}, $signed(srcaE) < $signed(srcbE)};
            4'b0110: aluE = {{(XLEN-1){1'b0}}, srcaE < srcbE};
            4'b0111: aluE = srcaE << shamt;
            4'b1000: aluE = srcaE >> shamt;
            4'b1001: aluE = $unsigned($signed(srcaE) >>> shamt);
            default: aluE = '0;
        endcase
    end

    assign pcplus4E = id_ex_q.pc + XLEN'(4);
    assign targetE  = id_ex_q.pc + id_ex_q.simm;
    assign takenE   = id_ex_q.jump | (id_ex_q.branch & ((aluE == '0) ^ id_ex_q.branchne));
    assign lwstall  = id_ex_q.memtoreg && id_ex_q.rd != 5'd0 &&
                      (id_ex_q.rd == rs1D || id_ex_q.rd == rs2D);

    always_comb begin
        pc_d          = pc_q + XLEN'(4);
        if_id_d.instr = instrF;
        if_id_d.pc    = pc_q;
        // Flush outranks the load-use stall: the stalled instruction is squashed anyway.
        if (takenE) begin
            pc_d    = targetE;
            if_id_d = '0;
        end else if (lwstall) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
        end

        id_ex_d.regwrite   = regwriteD;
        id_ex_d.memtoreg   = memtoregD;
        id_ex_d.memwrite   = memwriteD;
        id_ex_d.alusrcimm  = alusrcimmD;
        id_ex_d.jump       = jumpD;
        id_ex_d.branch     = branchD;
        id_ex_d.branchne   = branchneD;
        id_ex_d.alucontrol = alucontrolD;
        id_ex_d.rs1        = rs1D;
        id_ex_d.rs2        = rs2D;
        id_ex_d.rd         = if_id_q.instr[11:7];
        id_ex_d.rd1        = rd1D;
        id_ex_d.rd2        = rd2D;
        id_ex_d.simm       = simmD;
        id_ex_d.pc         = if_id_q.pc;
        if (takenE || lwstall) begin
            id_ex_d = '0;
        end

        ex_mem_d.regwrite  = id_ex_q.regwrite;
        ex_mem_d.memtoreg  = id_ex_q.memtoreg;
        ex_mem_d.memwrite  = id_ex_q.memwrite;
        ex_mem_d.jump      = id_ex_q.jump;
        ex_mem_d.rd        = id_ex_q.rd;
        ex_mem_d.aluout    = aluE;
        ex_mem_d.writedata = wdataE;
        ex_mem_d.pcplus4   = pcplus4E;

        mem_wb_d.regwrite  = ex_mem_q.regwrite;
        mem_wb_d.memtoreg  = ex_mem_q.memtoreg;
        mem_wb_d.jump      = ex_mem_q.jump;
        mem_wb_d.rd        = ex_mem_q.rd;
        mem_wb_d.aluout    = ex_mem_q.aluout;
        mem_wb_d.readdata  = readdataM;
        mem_wb_d.pcplus4   = ex_mem_q.pcplus4;

        rf_d = rf_q;
        if (mem_wb_q.regwrite && mem_wb_q.rd != 5'd0) begin
            rf_d[mem_wb_q.rd] = resultW;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            rf_q     <= '{default: '0};
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
            rf_q     <= rf_d;
        end
    end

    assign pcF        = pc_q;
    assign instrD     = if_id_q.instr;
    assign aluoutM    = ex_mem_q.aluout;
    assign writedataM = ex_mem_q.writedata;
    assign memwriteM  = ex_mem_q.memwrite;

`ifdef PIPE_DATAPATH_PERF_EN
    // Valid bits shadow the pipe so retirement ignores bubbles; instr 0 is a bubble.
    logic        vld_e_q, vld_m_q, vld_w_q, vld_e_d;
    logic [31:0] cycle_q, cycle_d, retire_q, retire_d, stall_q, stall_d;

    always_comb begin
        vld_e_d  = (if_id_q.instr != 32'd0) && !takenE && !lwstall;
        cycle_d  = cycle_q + 32'd1;
        retire_d = retire_q + {31'd0, vld_w_q};
        stall_d  = stall_q + {31'd0, takenE | lwstall};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_e_q  <= 1'b0;
            vld_m_q  <= 1'b0;
            vld_w_q  <= 1'b0;
            cycle_q  <= '0;
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            vld_e_q  <= vld_e_d;
            vld_m_q  <= vld_e_q;
            vld_w_q  <= vld_m_q;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            stall_q  <= stall_d;
        end
    end

    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;
    assign stall_cnt  = stall_q;
`endif

endmodule

// File: tb/tb_pipe_datapath.sv
// tb_pipe_datapath: directed bench for pipe_datapath (RESET_PC = 0x100).
// The bench plays controller (decodes instrD), instruction memory and load-data memory;
// stores are captured in a log (address, data, cycle) sampled on the falling edge.
module tb_pipe_datapath;

    logic        clk;
    logic        reset;
    logic [31:0] pcF, instrF, instrD;
    logic        regwriteD, memtoregD, memwriteD, alusrcimmD, jumpD, branchD, branchneD;
    logic [3:0]  alucontrolD;
    logic [31:0] simmD, aluoutM, writedataM, readdataM;
    logic        memwriteM;

    logic [31:0] imem [256];
    logic [31:0] dmem [256];

    logic [63:0] log_ad [$];
    int          log_cyc [$];
    int          cyc;
    int          n_chk;
    int          n_pass;
    logic [31:0] exp_d [12];

    pipe_datapath #(
        .XLEN     (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pcF         (pcF),
        .instrF      (instrF),
        .instrD      (instrD),
        .regwriteD   (regwriteD),
        .memtoregD   (memtoregD),
        .memwriteD   (memwriteD),
        .alusrcimmD  (alusrcimmD),
        .jumpD       (jumpD),
        .branchD     (branchD),
        .branchneD   (branchneD),
        .alucontrolD (alucontrolD),
        .simmD       (simmD),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .memwriteM   (memwriteM),
        .readdataM   (readdataM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instrF    = imem[pcF[9:2]];
    assign readdataM = dmem[aluoutM[9:2]];

    // ---------------- controller ----------------
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt,
                                          input logic is_r);
        case (f3)
            3'b000:  return (is_r && alt) ? 4'b0001 : 4'b0000;
            3'b001:  return 4'b0111;
            3'b010:  return 4'b0101;
            3'b011:  return 4'b0110;
            3'b100:  return 4'b0100;
            3'b101:  return alt ? 4'b1001 : 4'b1000;
            3'b110:  return 4'b0011;
            default: return 4'b0010;
        endcase
    endfunction

    always_comb begin
        regwriteD   = 1'b0;
        memtoregD   = 1'b0;
        memwriteD   = 1'b0;
        alusrcimmD  = 1'b0;
        jumpD       = 1'b0;
        branchD     = 1'b0;
        branchneD   = 1'b0;
        alucontrolD = 4'b0000;
        simmD       = 32'd0;
        case (instrD[6:0])
            7'h13: begin
                regwriteD   = 1'b1;
                alusrcimmD  = 1'b1;
                alucontrolD = alu_of(instrD[14:12], instrD[30], 1'b0);
                simmD       = {{20{instrD[31]}}, instrD[31:20]};
            end
            7'h33: begin
                regwriteD   = 1'b1;
                alucontrolD = alu_of(instrD[14:12], instrD[30], 1'b1);
            end
            7'h03: begin
                regwriteD  = 1'b1;
                memtoregD  = 1'b1;
                alusrcimmD = 1'b1;
                simmD      = {{20{instrD[31]}}, instrD[31:20]};
            end
            7'h23: begin
                memwriteD  = 1'b1;
                alusrcimmD = 1'b1;
                simmD      = {{20{instrD[31]}}, instrD[31:25], instrD[11:7]};
            end
            7'h63: begin
                branchD     = 1'b1;
                branchneD   = instrD[12];
                alucontrolD = 4'b0001;
                simmD = {{19{instrD[31]}}, instrD[31], instrD[7], instrD[30:25],
                         instrD[11:8], 1'b0};
            end
            7'h6f: begin
                jumpD     = 1'b1;
                regwriteD = 1'b1;
                simmD = {{11{instrD[31]}}, instrD[31], instrD[19:12], instrD[20],
                         instrD[30:21], 1'b0};
            end
            default: ;
        endcase
    end

    // ---------------- store log ----------------
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            log_ad.delete();
            log_cyc.delete();
        end else begin
            cyc++;
            if (memwriteM === 1'b1) begin
                log_ad.push_back({aluoutM, writedataM});
                log_cyc.push_back(cyc);
            end
        end
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'h13};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'h03};
    endfunction

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] sw(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] br(input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_store(input int idx, input string tag, input logic [31:0] addr,
                               input logic [31:0] data, input int exp_cyc);
        logic [63:0] obs_ad;
        int          obs_c;
        obs_ad = '0;
        obs_c  = -1;
        if (idx < log_ad.size()) begin
            obs_ad = log_ad[idx];
            obs_c  = log_cyc[idx];
        end
        check({tag, ".st"}, obs_ad, {addr, data});
        check({tag, ".cyc"}, 64'(obs_c), 64'(exp_cyc));
    endtask

    task automatic put(input logic [31:0] addr, input logic [31:0] ins);
        imem[addr[9:2]] = ins;
    endtask

    task automatic hold_reset();
        @(negedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = 32'd0;
            dmem[i] = 32'd0;
        end

        // Reset state and first PC steps.
        #1 reset = 1'b1;
        #1;
        check("rst.pcF", 64'(pcF), 64'h100);
        check("rst.memwriteM", 64'(memwriteM), 64'd0);
        check("rst.aluoutM", 64'(aluoutM), 64'd0);
        check("rst.writedataM", 64'(writedataM), 64'd0);
        check("rst.instrD", 64'(instrD), 64'd0);
        release_reset();
        step(1);
        check("rst.pc1", 64'(pcF), 64'h104);
        step(1);
        check("rst.pc2", 64'(pcF), 64'h108);

        // Dependent chain plus one instance of each ALU op, then stores of the results.
        hold_reset();
        put(32'h100, addi(5'd1, 5'd0, 12'd5));
        put(32'h104, rtype(7'h00, 3'b000, 5'd2, 5'd1, 5'd1));
        put(32'h108, rtype(7'h00, 3'b000, 5'd3, 5'd2, 5'd1));
        put(32'h10C, addi(5'd7, 5'd0, 12'hFFD));
        put(32'h110, rtype(7'h20, 3'b000, 5'd8, 5'd1, 5'd7));
        put(32'h114, rtype(7'h00, 3'b010, 5'd9, 5'd7, 5'd1));
        put(32'h118, rtype(7'h00, 3'b011, 5'd10, 5'd7, 5'd1));
        put(32'h11C, rtype(7'h20, 3'b101, 5'd11, 5'd7, 5'd1));
        put(32'h120, rtype(7'h00, 3'b101, 5'd12, 5'd7, 5'd1));
        put(32'h124, rtype(7'h00, 3'b001, 5'd13, 5'd1, 5'd1));
        put(32'h128, rtype(7'h00, 3'b100, 5'd14, 5'd7, 5'd1));
        put(32'h12C, rtype(7'h00, 3'b111, 5'd15, 5'd7, 5'd1));
        put(32'h130, rtype(7'h00, 3'b110, 5'd16, 5'd7, 5'd1));
        put(32'h134, addi(5'd0, 5'd0, 12'd9));
        put(32'h138, sw(5'd2, 5'd0, 12'd0));
        put(32'h13C, sw(5'd3, 5'd0, 12'd4));
        for (int i = 0; i < 9; i++) begin
            put(32'(32'h140 + 4 * i), sw(5'(8 + i), 5'd0, 12'(8 + 4 * i)));
        end
        put(32'h164, sw(5'd0, 5'd0, 12'd44));
        release_reset();
        step(30);
        exp_d = '{32'd10, 32'd15, 32'd8, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'h07FF_FFFF,
                  32'hA0, 32'hFFFF_FFF8, 32'd5, 32'hFFFF_FFFD, 32'd0};
        check("alu.nstores", 64'(log_ad.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            check_store(i, $sformatf("alu.s%0d", i), 32'(4 * i), exp_d[i], 17 + i);
        end
        check("alu.pc30", 64'(pcF), 64'h178);

        // Load-use: exactly one hold of pcF, then the load result through WB forwarding.
        hold_reset();
        dmem[16] = 32'd7;
        put(32'h100, lw(5'd4, 5'd0, 12'h040));
        put(32'h104, rtype(7'h00, 3'b000, 5'd5, 5'd4, 5'd4));
        put(32'h108, sw(5'd5, 5'd0, 12'd0));
        release_reset();
        step(1);
        check("lu.pc1", 64'(pcF), 64'h104);
        step(1);
        check("lu.pc2", 64'(pcF), 64'h108);
        step(1);
        check("lu.pc3", 64'(pcF), 64'h108);
        step(1);
        check("lu.pc4", 64'(pcF), 64'h10C);
        step(5);
        check("lu.nstores", 64'(log_ad.size()), 64'd1);
        check_store(0, "lu.x5", 32'd0, 32'd14, 6);

        // Taken beq: the two younger instructions are squashed.
        hold_reset();
        put(32'h100, br(3'b000, 5'd0, 5'd0, 13'd12));
        put(32'h104, addi(5'd20, 5'd0, 12'd1));
        put(32'h108, sw(5'd0, 5'd0, 12'd48));
        put(32'h10C, sw(5'd20, 5'd0, 12'd52));
        release_reset();
        step(2);
        check("beq.pc2", 64'(pcF), 64'h108);
        step(1);
        check("beq.pc3", 64'(pcF), 64'h10C);
        step(5);
        check("beq.nstores", 64'(log_ad.size()), 64'd1);
        check_store(0, "beq.x20", 32'd52, 32'd0, 6);

        // Same code with bne: not taken, everything executes.
        hold_reset();
        put(32'h100, br(3'b001, 5'd0, 5'd0, 13'd12));
        put(32'h104, addi(5'd20, 5'd0, 12'd1));
        put(32'h108, sw(5'd0, 5'd0, 12'd48));
        put(32'h10C, sw(5'd20, 5'd0, 12'd52));
        release_reset();
        step(4);
        check("bne.pc4", 64'(pcF), 64'h110);
        step(4);
        check("bne.nstores", 64'(log_ad.size()), 64'd2);
        check_store(0, "bne.s48", 32'd48, 32'd0, 5);
        check_store(1, "bne.x20", 32'd52, 32'd1, 6);

        // jal 0x100 -> 0x20, then jal x1 at 0x20 -> 0x60 linking 0x24.
        hold_reset();
        put(32'h100, jal(5'd0, 21'h1FFF20));
        put(32'h020, jal(5'd1, 21'h000040));
        put(32'h024, addi(5'd1, 5'd0, 12'h7FF));
        put(32'h028, addi(5'd1, 5'd0, 12'd1));
        put(32'h060, sw(5'd1, 5'd0, 12'd56));
        release_reset();
        step(3);
        check("jal.pc3", 64'(pcF), 64'h20);
        step(3);
        check("jal.pc6", 64'(pcF), 64'h60);
        step(6);
        check("jal.nstores", 64'(log_ad.size()), 64'd1);
        check_store(0, "jal.x1", 32'd56, 32'h24, 9);

        // Store data forwarded from MEM, then an asynchronous reset mid-cycle.
        hold_reset();
        put(32'h100, addi(5'd6, 5'd0, 12'h055));
        put(32'h104, sw(5'd6, 5'd0, 12'd8));
        release_reset();
        step(3);
        check("st.memwrite3", 64'(memwriteM), 64'd0);
        step(1);
        check("st.memwriteM", 64'(memwriteM), 64'd1);
        check("st.aluoutM", 64'(aluoutM), 64'd8);
        check("st.writedataM", 64'(writedataM), 64'h55);
        check("st.pc4", 64'(pcF), 64'h110);
        #1 reset = 1'b1;
        #1;
        check("arst.pcF", 64'(pcF), 64'h100);
        check("arst.memwriteM", 64'(memwriteM), 64'd0);
        check("arst.aluoutM", 64'(aluoutM), 64'd0);
        check("arst.writedataM", 64'(writedataM), 64'd0);
        release_reset();
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_datapath.md
Name: pipe_datapath

Overview:
- Five-stage (IF/ID/EX/MEM/WB) successor of the single-cycle RV32 datapath, parametrised in data width and reset vector.
- Owns the PC, pipeline registers, register file, ALU, forwarding, load-use stall and branch/jump flush.
- The external controller decodes instrD and drives ID-stage control. Instruction and data memories sit outside the block.

Parameters:
- XLEN, 32, datapath/register width; PC also XLEN wide.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pcF  out  XLEN  fetch address to instruction memory.
- instrF  in  32  instruction at pcF, combinational.
- instrD  out  32  ID-stage instruction, to controller.
- regwriteD  in  1  write rd in WB.
- memtoregD  in  1  result taken from load data.
- memwriteD  in  1  store in MEM.
- alusrcimmD  in  1  ALU B operand is the immediate.
- jumpD  in  1  JAL: redirect to pc+simm, write pc+4.
- branchD  in  1  conditional branch.
- branchneD  in  1  with branchD: taken on !zero; else taken on zero.
- alucontrolD  in  4  ALU op.
- simmD  in  XLEN  sign-extended immediate for instrD.
- aluoutM  out  XLEN  data address.
- writedataM  out  XLEN  store data.
- memwriteM  out  1  store strobe.
- readdataM  in  XLEN  load data, combinational in MEM.

Behaviour:
- Reset (async):
  - pcF=RESET_PC.
  - All pipeline registers cleared to bubble: instr=0, all control 0.
  - Register file cleared to 0.
  - memwriteM=0, aluoutM=0, writedataM=0.
- Register file:
  - 32 x XLEN entries; x0 reads 0 and ignores writes.
  - Written at the WB clock edge.
  - A same-cycle WB write to rs1/rs2 bypasses to the ID read.
- ALU op codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount is srcb[$clog2(XLEN)-1:0].
  - All other codes produce 0.
  - zero = (result==0). Arithmetic wraps modulo 2^XLEN.
- Forwarding:
  - EX operands A and B-register are taken from MEM if regwriteM && rdM!=0 && rdM==rsE.
  - Else from WB on the same condition with rdW.
  - Else from the ID/EX value. MEM has priority over WB.
  - The store data path uses the same forwarding.
- MEM-stage forward value: aluoutM, or pcplus4M for a jump.
- Load-use stall:
  - Condition: memtoregE && rdE!=0 && (rdE==rs1D || rdE==rs2D).
  - Effect: hold pcF and IF/ID for 1 cycle; insert a bubble into ID/EX.
- Branch/jump:
  - Resolved in EX. taken = jumpE | (branchE & (zero ^ branchneE)).
  - Target = pcE + simmE.
  - On taken: pcF<=target; IF/ID and ID/EX flushed to bubble (2-cycle penalty).
  - Flush has priority over a simultaneous load-use stall.
- Writeback value: memtoregW ? readdataW : (jumpW ? pcplus4W : aluoutW).
- Latency: an instruction writes its register 4 cycles after leaving IF.
- pcF advances by 4 every unstalled, unflushed cycle; wraps at 2^XLEN.

Optional Feature:
- Macro: PIPE_DATAPATH_PERF_EN.
- When defined, the block adds three outputs:
  - cycle_cnt[31:0]: +1 every cycle after reset.
  - retire_cnt[31:0]: +1 per non-bubble instruction leaving WB.
  - stall_cnt[31:0]: +1 per load-use stall or flush cycle.
- All three counters are reset to 0 and wrap at 2^32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x100 -> pcF=0x100 asynchronously, memwriteM=0; after release pcF=0x104,0x108 on successive edges.
- Back-to-back dependency:
  - addi x1,x0,5; add x2,x1,x1; add x3,x2,x1.
  - Required: x2=10, x3=15, no stalls (MEM and WB forwarding).
- Load-use:
  - Memory word at 0x40 holds 7; lw x4,0x40(x0); add x5,x4,x4.
  - Required: x5=14; pcF holds exactly 1 cycle; one bubble reaches EX.
- Branch taken:
  - beq x0,x0,+12 at 0x0.
  - Required: next fetch 0xC; the two instructions fetched at 0x4 and 0x8 never write registers or memory.
  - Same stimulus with bne -> falls through with no flush.
- JAL at 0x20, simm=0x40, rd=x1 -> pcF=0x60, x1=0x24.
- Store forwarding: addi x6,x0,0x55; sw x6,8(x0) -> memwriteM=1 with aluoutM=8 and writedataM=0x55 in the same cycle.
